ifetch_stage: RTL and testbench



---
 rtl/ifetch_stage.sv | 96 +++++++++
 tb/tb_ifetch_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address and
// registers the fetched instruction into the IF/ID pipeline register.
module ifetch_stage #(
  parameter int          ADDR_W  = 6,
  parameter int          INSTR_W = 32,
  parameter logic [3:0]  HALT_OP = 4'b1111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic               if_valid,
  output logic               halted,
  output logic               dbg_state
);

  // Flow control: stall=1 means decode cannot accept a new IF/ID entry, so the
  // register and the PC hold. branch_taken outranks stall, so a redirect is never lost.
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]    ifpc_q, ifpc_d;
  logic                 valid_q, valid_d;
  logic                 halted_q, halted_d;
  logic [3:0]           opcode;

  assign opcode = imem_data[INSTR_W-1:INSTR_W-4];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= '0;
      instr_q  <= '0;
      ifpc_q   <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ifpc_q   <= ifpc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ifpc_d   = ifpc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    case (state_q)
      RUN: begin
        if (branch_taken) begin
          // Flush: whatever is on imem_data this cycle is dropped.
          pc_d    = branch_target;
          instr_d = '0;
          ifpc_d  = '0;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d = imem_data;
          ifpc_d  = pc_q;
          valid_d = 1'b1;
          if (opcode == HALT_OP) begin
            halted_d = 1'b1;
            state_d  = HALTED;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      HALTED: begin
        // HALT stays visible until decode accepts it, then only bubbles follow.
        if (!stall) valid_d = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  assign imem_addr = pc_q;
  assign if_instr  = instr_q;
  assign if_pc     = ifpc_q;
  assign if_valid  = valid_q;
  assign halted    = halted_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: free-run, stall, branch flush, wrap, HALT and async reset.
module tb_ifetch_stage;

  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 32;

  logic               clk;
  logic               reset;
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_target;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               if_valid;
  logic               halted;
  logic               dbg_state;

  logic [INSTR_W-1:0] mem [64];
  int n_checks = 0;
  int n_fails  = 0;

  ifetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .if_instr      (if_instr),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .halted        (halted),
    .dbg_state     (dbg_state)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},   32'(imem_addr), 32'd0);
    check({tag, "_instr"},  if_instr,       32'd0);
    check({tag, "_pc"},     32'(if_pc),     32'd0);
    check({tag, "_valid"},  32'(if_valid),  32'd0);
    check({tag, "_halted"}, 32'(halted),    32'd0);
    check({tag, "_state"},  32'(dbg_state), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0100 + 32'(i);
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;

    // Reset then free-run
    #2;
    check_reset_vals("reset");
    #18 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("run_pc",    32'(if_pc),     32'(k));
      check("run_instr", if_instr,       32'h0000_0100 + 32'(k));
      check("run_valid", 32'(if_valid),  32'd1);
      check("run_addr",  32'(imem_addr), 32'(k + 1));
    end

    // Stall at pc=5
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_addr",  32'(imem_addr), 32'd5);
      check("stall_pc",    32'(if_pc),     32'd4);
      check("stall_instr", if_instr,       32'h0000_0104);
      check("stall_valid", 32'(if_valid),  32'd1);
    end
    stall = 1'b0;
    tick();
    check("unstall_pc5", 32'(if_pc), 32'd5);
    tick();
    check("unstall_pc6", 32'(if_pc),     32'd6);
    check("unstall_addr", 32'(imem_addr), 32'd7);

    // Branch with flush at pc=7
    branch_taken = 1'b1; branch_target = 6'd20;
    tick();
    branch_taken = 1'b0;
    check("br_valid", 32'(if_valid),  32'd0);
    check("br_addr",  32'(imem_addr), 32'd20);
    check("br_instr", if_instr,       32'd0);
    check("br_pc",    32'(if_pc),     32'd0);
    tick();
    check("br_next_pc",    32'(if_pc),    32'd20);
    check("br_next_valid", 32'(if_valid), 32'd1);
    check("br_next_instr", if_instr,      32'h0000_0114);

    // Branch together with stall: branch wins
    branch_taken = 1'b1; stall = 1'b1; branch_target = 6'd20;
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    check("brst_valid", 32'(if_valid),  32'd0);
    check("brst_addr",  32'(imem_addr), 32'd20);
    tick();
    check("brst_next_pc",    32'(if_pc),    32'd20);
    check("brst_next_valid", 32'(if_valid), 32'd1);

    // Wrap-around 62, 63, 0, 1
    branch_taken = 1'b1; branch_target = 6'd62;
    tick();
    branch_taken = 1'b0;
    check("wrap_addr", 32'(imem_addr), 32'd62);
    tick(); check("wrap_pc62", 32'(if_pc), 32'd62);
    tick(); check("wrap_pc63", 32'(if_pc), 32'd63);
    check("wrap_addr0", 32'(imem_addr), 32'd0);
    tick(); check("wrap_pc0", 32'(if_pc), 32'd0);
    check("wrap_instr0", if_instr, 32'h0000_0100);
    tick(); check("wrap_pc1", 32'(if_pc), 32'd1);
    check("wrap_halted", 32'(halted), 32'd0);

    // HALT at address 3
    reset = 1'b1;
    #1;
    check_reset_vals("rst2");
    mem[3] = 32'hF000_0000;
    #2 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("h_run_pc", 32'(if_pc), 32'(k));
    end
    check("halt_instr",  if_instr,       32'hF000_0000);
    check("halt_flag",   32'(halted),    32'd1);
    check("halt_valid",  32'(if_valid),  32'd1);
    check("halt_addr",   32'(imem_addr), 32'd3);
    check("halt_state",  32'(dbg_state), 32'd1);
    tick();
    check("halt_bubble", 32'(if_valid),  32'd0);
    check("halt_pc",     32'(if_pc),     32'd3);
    check("halt_addr2",  32'(imem_addr), 32'd3);
    branch_taken = 1'b1; branch_target = 6'd10;
    tick();
    branch_taken = 1'b0;
    check("halt_br_addr",   32'(imem_addr), 32'd3);
    check("halt_br_flag",   32'(halted),    32'd1);
    check("halt_br_valid",  32'(if_valid),  32'd0);
    reset = 1'b1;
    #1;
    check_reset_vals("rst_halt");
    mem[3] = 32'h0000_0103;
    #2 reset = 1'b0;

    // Async reset mid-stall at pc=9
    for (int k = 0; k < 9; k++) tick();
    check("pre_async_addr", 32'(imem_addr), 32'd9);
    check("pre_async_pc",   32'(if_pc),     32'd8);
    stall = 1'b1;
    tick();
    check("async_stall_addr",  32'(imem_addr), 32'd9);
    check("async_stall_valid", 32'(if_valid),  32'd1);
    #2 reset = 1'b1;
    #1;
    check_reset_vals("async");
    stall = 1'b0;
    #1 reset = 1'b0;
    tick();
    check("post_async_pc",    32'(if_pc),    32'd0);
    check("post_async_valid", 32'(if_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
